// File: rtl/redun_mont_pkg.sv
`default_nettype none
// ============================================================================
// Module      : redun_mont_pkg
// Description : Shared types for the redundant-form Montgomery engine and its
//               iteration sequencer.
// Revision    : 1.0
// ============================================================================
package redun_mont_pkg;

  localparam int NUM_WRDS = 4;
  localparam int WRD_W    = 16;

  typedef logic [NUM_WRDS-1:0][WRD_W-1:0] redun0_t;

  localparam int SEQ_ITER_W = 64;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ISSUE = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_DONE  = 3'd3,
    SEQ_DRAIN = 3'd4
  } redun_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/redun_seq_wdog.sv
`default_nettype none
// ============================================================================
// Module      : redun_seq_wdog
// Description : Loadable saturating down-counter with an expired flag.
// Revision    : 1.0
// ============================================================================
module redun_seq_wdog #(
  parameter int CNT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/redun_mont_seq.sv
`default_nettype none
// ============================================================================
// Module      : redun_mont_seq
// Description : Issues T back-to-back squarings to redun_mont, feeding each
//               result back; abort, drain and watchdog handling. Optional
//               checkpoint strobes under `REDUN_SEQ_CKPT_EN.
// Revision    : 1.0
// ============================================================================
module redun_mont_seq
  import redun_mont_pkg::*;
#(
  parameter int ITER_W     = SEQ_ITER_W,
  parameter int WDOG_CYC   = 1024,
  parameter int CKPT_INTVL = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_locked,
  input  logic              i_start,
  input  redun0_t           i_sq_in,
  input  logic [ITER_W-1:0] i_iter,
  input  logic              i_abort,
  output logic              o_ready,
  output redun0_t           o_sq_out,
  output logic              o_valid,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic              o_err,
  output redun0_t           o_mul_sq,
  output logic              o_mul_val,
  input  redun0_t           i_mul_out,
  input  logic              i_mul_val,
  output logic              o_ckpt_val
);

  localparam logic [2:0] ST_IDLE  = SEQ_IDLE;
  localparam logic [2:0] ST_ISSUE = SEQ_ISSUE;
  localparam logic [2:0] ST_WAIT  = SEQ_WAIT;
  localparam logic [2:0] ST_DONE  = SEQ_DONE;
  localparam logic [2:0] ST_DRAIN = SEQ_DRAIN;

  // The issue cycle and the final sampling edge are both inside the budget, so a
  // result sampled WDOG_CYC edges after the issue cycle begins is still accepted.
  localparam int              WD_W    = $clog2(WDOG_CYC);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYC - 2);

  logic [2:0]        state_q, state_d;
  redun0_t           val_q, val_d;
  logic [ITER_W-1:0] tgt_q, tgt_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              err_q, valid_q, armed_q;
  logic              accept, err_set;
  logic              wd_load, wd_dec, wd_expired;

  assign o_ready    = (state_q == ST_IDLE) & i_locked & armed_q;
  assign accept     = i_start & o_ready;
  assign o_mul_val  = (state_q == ST_ISSUE);
  assign o_mul_sq   = val_q;
  assign o_valid    = valid_q;
  assign o_iter_cnt = cnt_q;
  assign o_err      = err_q;

  redun_seq_wdog #(
    .CNT_W (WD_W)
  ) u_wdog (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .dec_i      (wd_dec),
    .expired_o  (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_set = 1'b0;
    wd_load = 1'b0;
    wd_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        err_set = i_mul_val;
        if (accept) begin
          val_d   = i_sq_in;
          tgt_d   = i_iter;
          cnt_d   = '0;
          state_d = (i_iter == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        err_set = i_mul_val;
        wd_load = 1'b1;
        if (i_abort) begin
          state_d = ST_DRAIN;
          pend_d  = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_dec = 1'b1;
        // A result landing together with the abort is dropped and leaves nothing in flight.
        if (i_abort) begin
          state_d = ST_DRAIN;
          pend_d  = ~i_mul_val;
          wd_load = 1'b1;
        end else if (i_mul_val) begin
          val_d   = i_mul_out;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == tgt_q) ? ST_DONE : ST_ISSUE;
        end else if (wd_expired) begin
          err_set = 1'b1;
          state_d = ST_DRAIN;
          pend_d  = 1'b1;
          wd_load = 1'b1;
        end
      end
      ST_DONE: begin
        err_set = i_mul_val;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        wd_dec = 1'b1;
        if (!pend_q || i_mul_val || wd_expired) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= (accept ? 1'b0 : err_q) | err_set;
      valid_q <= (state_q == ST_DONE);
      armed_q <= 1'b1;
    end
  end

`ifdef REDUN_SEQ_CKPT_EN
  localparam logic [ITER_W-1:0] CKPT_N = ITER_W'(CKPT_INTVL);

  logic ckpt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ckpt_q <= 1'b0;
    end else begin
      ckpt_q <= (state_q == ST_WAIT) && i_mul_val && !i_abort &&
                ((cnt_d % CKPT_N) == '0) && (cnt_d != tgt_q);
    end
  end

  assign o_sq_out   = val_q;
  assign o_ckpt_val = ckpt_q;
`else
  redun0_t sq_out_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sq_out_q <= '0;
    end else if (state_d == ST_DONE) begin
      sq_out_q <= val_d;
    end
  end

  assign o_sq_out = sq_out_q;

  // The interval still has to be positive when checkpointing is compiled out.
  if (CKPT_INTVL >= 1) begin : g_ckpt_off
    assign o_ckpt_val = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: doc/redun_mont_seq.md
Name: redun_mont_seq

Overview:
- Iteration controller for the redundant-form Montgomery squaring engine (redun_mont) in the VDF datapath.
- Loads a start value and iteration count T, then issues T back-to-back squarings, feeding each engine result back as the next input.
- Returns the final value with a done pulse, plus iteration progress, abort and watchdog error handling.
- Sits in the engine clock domain, between the CDC FIFOs and redun_mont.

Parameters:
- ITER_W, 64, width of iteration count and counter.
- WDOG_CYC, 1024, max cycles from an issue to the engine result before error.
- CKPT_INTVL, 1024, checkpoint interval in iterations (used only with the optional feature).

Ports:
- i_clk  in  1  engine clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_locked  in  1  clock locked; gates acceptance of new jobs.
- i_start  in  1  job request, sampled when o_ready=1.
- i_sq_in  in  redun0_t  initial value.
- i_iter  in  ITER_W  iteration count T.
- i_abort  in  1  cancel current job.
- o_ready  out  1  can accept job.
- o_sq_out  out  redun0_t  final or current value.
- o_valid  out  1  one-cycle done pulse.
- o_iter_cnt  out  ITER_W  completed iterations.
- o_err  out  1  sticky watchdog/protocol error.
- o_mul_sq  out  redun0_t  engine operand.
- o_mul_val  out  1  engine operand strobe.
- i_mul_out  in  redun0_t  engine result.
- i_mul_val  in  1  engine result strobe.
- o_ckpt_val  out  1  checkpoint strobe (optional feature).

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including o_sq_out, o_iter_cnt and o_err; o_ready=0 until the first clock after release.
- o_ready = (state==IDLE) & i_locked.

State machine:
- IDLE, start accepted (i_start & o_ready):
  - Latch i_sq_in into the value register and i_iter into the target; clear the counter.
  - T==0 -> DONE; else -> ISSUE.
- ISSUE:
  - o_mul_val=1 for exactly one cycle; o_mul_sq = value register (registered output).
  - Load the watchdog with WDOG_CYC -> WAIT.
- WAIT:
  - Watchdog decrements each cycle.
  - On i_mul_val: value <= i_mul_out; counter+1.
  - If the new count == T -> DONE; else -> ISSUE.
  - Per-iteration latency = engine latency + 1.
- DONE:
  - o_valid=1 for one cycle; o_sq_out holds the value (held stable until the next job starts) -> IDLE.
  - T==0 returns i_sq_in unchanged, 2 cycles after start.
- Watchdog reaches 0 in WAIT: set o_err -> DRAIN.
- i_abort in ISSUE or WAIT: -> DRAIN; o_valid is never pulsed. i_abort in IDLE or DONE has no effect (the DONE pulse completes).
- DRAIN:
  - If a result is outstanding, wait for i_mul_val (discarded) or a fresh WDOG_CYC timeout, then -> IDLE.
  - If the abort came in ISSUE the same cycle o_mul_val fired, that result counts as outstanding.
  - Guarantees no stale result reaches the next job.
- i_mul_val in IDLE, ISSUE or DONE: ignored; sets o_err.
- o_err: sticky; cleared only by reset or by the next accepted start.
- Counter: ITER_W-bit, no wrap (max T = 2^ITER_W - 1). o_iter_cnt is live throughout the job.
- i_locked falling mid-job: no state effect (upstream resets via the reset).

Optional Feature:
- Macro REDUN_SEQ_CKPT_EN.
- Defined: when the counter increments to a nonzero multiple of CKPT_INTVL and count != T, o_ckpt_val pulses for one cycle the cycle after the update, with o_sq_out showing the current value. o_sq_out tracks the value register continuously during the job.
- Undefined: o_ckpt_val tied 0; o_sq_out updates only on entry to DONE; no checkpoint comparator logic.

Decomposition:
- Add to redun_mont_pkg:
  - redun_seq_state_t enum (IDLE, ISSUE, WAIT, DONE, DRAIN).
  - ITER_W default constant.
- redun0_t and NUM_WRDS are already in the package.
- One sub-module, redun_seq_wdog: loadable down-counter with an expired flag, reused by WAIT and DRAIN.

Test Plan:
- Bench model: engine of fixed latency 5, modular square mod a small test modulus.
- T=3, i_sq_in=2, modulus 1000003 -> o_valid after 3×6+2 cycles; o_sq_out=256 in normal form; o_iter_cnt=3; three o_mul_val pulses.
- T=0, i_sq_in=7 -> o_valid on the 2nd cycle after start; o_sq_out=7; no o_mul_val.
- T=10, i_abort at iteration 4 while a result is in flight -> no o_valid; result discarded; o_ready returns; a new job T=1, value 3 yields 9.
- Engine never returns i_mul_val, WDOG_CYC=16 -> o_err=1 within 16 cycles of the issue; back in IDLE after DRAIN timeout; next start clears o_err.
- i_locked=0 with i_start high -> not accepted, no engine strobes. Async reset mid-WAIT -> all outputs 0 immediately.
- REDUN_SEQ_CKPT_EN, CKPT_INTVL=4, T=10 -> o_ckpt_val pulses after iterations 4 and 8 only; none at 10.
